// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder; also exposes the carry into
// its top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: digit-serial WIDTH-bit adder, CHUNK bits per clock, LSB chunk
// first, with valid/ready handshakes and sum/carry-out/signed-overflow results.
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $fatal(1, "multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_w;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] s;
    logic             co, c_msb;
    logic             last;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x     (a_r[cnt*CHUNK +: CHUNK]),
        .y     (b_r[cnt*CHUNK +: CHUNK]),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    assign last      = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Partial sum with the current chunk merged in; becomes visible only on the last chunk.
    always_comb begin
        acc_w = acc;
        acc_w[cnt*CHUNK +: CHUNK] = s;
    end

    always_comb begin
        state_n = state;
        state_n = (state == IDLE && in_valid)  ? CALC :
                  (state == CALC && last)      ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                a_r   <= a;
                b_r   <= b;
                carry <= cin;
                cnt   <= '0;
            end
            if (state == CALC) begin
                acc   <= acc_w;
                carry <= co;
                if (last) begin
                    sum  <= acc_w;
                    cout <= co;
                    ovf  <= co ^ c_msb;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: directed vectors with literal expectations plus an
// arithmetic reference model compared against the 16/4 build every cycle.
module tb_multi_cycle_adder;
    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          in_ready, out_valid, cout, ovf;
    logic [W-1:0]  sum;

    logic          in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0]    a8 = '0, b8 = '0;
    logic          in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]    sum8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_cycle_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 busy for N cycles, 2 holding a result.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_sum = '0, p_sum;
    logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout, p_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_sum = '0;
            m_cout = 1'b0;
            m_ovf = 1'b0;
        end
        check("model in_ready", 32'(in_ready), 32'(m_phase == 0));
        check("model out_valid", 32'(out_valid), 32'(m_phase == 2));
        check("model sum", 32'(sum), 32'(m_sum));
        check("model cout", 32'(cout), 32'(m_cout));
        check("model ovf", 32'(ovf), 32'(m_ovf));
        if (rst_n) begin
            if (m_phase == 0 && in_valid) begin
                int signed ss;
                logic [W:0] us;
                us = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
                p_sum = us[W-1:0];
                p_cout = us[W];
                p_ovf = (ss > 32767) || (ss < -32768);
                m_left = N;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_sum = p_sum;
                    m_cout = p_cout;
                    m_ovf = p_ovf;
                end
            end else if (m_phase == 2 && out_ready) begin
                m_phase = 0;
            end
        end
    end

    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        int k = 0;
        while (!in_ready && k < 30) begin
            @(posedge clk); #1; k++;
        end
        check("wait in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(N));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back to idle", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic [W-1:0] es, input logic ec, input logic eo);
        start_op(xa, xb, xc);
        wait_done(name);
        check({name, " sum"}, 32'(sum), 32'(es));
        check({name, " cout"}, 32'(cout), 32'(ec));
        check({name, " ovf"}, 32'(ovf), 32'(eo));
        consume();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'h0000);
        check("reset cout/ovf", 32'({cout, ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("0+1",         16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
        do_op("FFFF+1",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("000F+0+cin",  16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
        do_op("7FFF+1",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("8000+8000",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        start_op(16'hABCD, 16'h1111, 1'b0);
        wait_done("hold");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'(i * 16'h1357);
            b = ~a;
            cin = i[1];
            @(posedge clk); #1;
            check("hold sum", 32'(sum), 32'hBCDE);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        consume();

        start_op(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst sum", 32'(sum), 32'h0000);
        check("async rst cout/ovf", 32'({cout, ovf}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8 not yet valid", 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        check("w8 latency 1", 32'(out_valid8), 32'd1);
        check("w8 sum", 32'(sum8), 32'hFF);
        check("w8 cout", 32'(cout8), 32'd1);
        check("w8 ovf", 32'(ovf8), 32'd0);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8 idle", 32'(in_ready8), 32'd1);

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
